// File: rtl/alu_serial_if.sv
// Request/response bundle for the bit-serial ALU.
// The master issues operations and consumes results; the slave is the ALU.
interface alu_serial_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] result;
  logic       carry;
  logic       zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carry, zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry, zero
  );
endinterface

// File: rtl/alu_serial.sv
// Bit-serial 4-bit ALU. An accepted request is processed LSB first over
// four BUSY cycles; the finished word is held in DONE until consumed.
// The published result/carry/zero registers only update when a word is
// complete, so partial results never leave the block.
module alu_serial (
  input  logic       clk,
  input  logic       rst_n,
  alu_serial_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [2:0] {
    OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADD, OP_SUB, OP_LAND, OP_RSVD
  } op_t;

  state_t     state_reg, state_next;
  op_t        op_reg;
  logic [3:0] a_reg, b_reg;
  logic [1:0] cnt_reg;
  logic       c_reg;            // serial carry for ADD/SUB
  logic       any_a_reg;        // running OR of A bits for LAND
  logic       any_b_reg;        // running OR of B bits for LAND
  logic [3:0] work_reg;         // partially built word, private to the block
  logic [3:0] work_next;
  logic [3:0] result_reg;
  logic       carry_reg;
  logic       zero_reg;

  logic       in_ready, out_valid;
  logic       accept, busy, last_bit;
  logic       a_bit, b_bit, b_eff;
  logic       bit_val, carry_next, carry_final;
  logic [3:0] final_word;

  assign accept   = bus.in_valid && in_ready;
  assign busy     = (state_reg == BUSY);
  assign last_bit = busy && (cnt_reg == 2'd3);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (cnt_reg == 2'd3) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One bit-slice of the datapath, selected by the bit counter
  always_comb begin
    a_bit      = a_reg[cnt_reg];
    b_bit      = b_reg[cnt_reg];
    b_eff      = (op_reg == OP_SUB) ? ~b_bit : b_bit;
    carry_next = (a_bit & b_eff) | (c_reg & (a_bit ^ b_eff));
    bit_val    = 1'b0;
    case (op_reg)
      OP_AND:  bit_val = a_bit & b_bit;
      OP_OR:   bit_val = a_bit | b_bit;
      OP_XOR:  bit_val = a_bit ^ b_bit;
      OP_NOT:  bit_val = ~a_bit;
      OP_ADD,
      OP_SUB:  bit_val = a_bit ^ b_eff ^ c_reg;
      default: bit_val = 1'b0;  // LAND builds its answer from the OR flags
    endcase
  end

  // Each work bit is written only on the cycle its counter value comes up
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_work_bit
      assign work_next[gi] = (busy && (cnt_reg == 2'(gi))) ? bit_val : work_reg[gi];
    end
  endgenerate

  // Word presented at completion; the last bit comes straight from the slice
  always_comb begin
    final_word  = work_next;
    carry_final = 1'b0;
    case (op_reg)
      OP_LAND: final_word = {3'b000, (any_a_reg | a_bit) & (any_b_reg | b_bit)};
      OP_ADD,
      OP_SUB:  carry_final = carry_next;
      default: carry_final = 1'b0;
    endcase
  end

  // Operand capture, serial state and published result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_reg     <= OP_AND;
      a_reg      <= 4'b0000;
      b_reg      <= 4'b0000;
      cnt_reg    <= 2'd0;
      c_reg      <= 1'b0;
      any_a_reg  <= 1'b0;
      any_b_reg  <= 1'b0;
      work_reg   <= 4'b0000;
      result_reg <= 4'b0000;
      carry_reg  <= 1'b0;
      zero_reg   <= 1'b1;
    end else if (accept) begin
      op_reg    <= op_t'(bus.op);
      a_reg     <= bus.a;
      b_reg     <= bus.b;
      cnt_reg   <= 2'd0;
      c_reg     <= (bus.op == OP_SUB);  // SUB is A + ~B + 1
      any_a_reg <= 1'b0;
      any_b_reg <= 1'b0;
      work_reg  <= 4'b0000;
    end else if (busy) begin
      cnt_reg   <= cnt_reg + 2'd1;
      c_reg     <= carry_next;
      any_a_reg <= any_a_reg | a_bit;
      any_b_reg <= any_b_reg | b_bit;
      work_reg  <= work_next;
      if (last_bit) begin
        result_reg <= final_word;
        carry_reg  <= carry_final;
        zero_reg   <= (final_word == 4'b0000);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result_reg;
  assign bus.carry     = carry_reg;
  assign bus.zero      = zero_reg;

endmodule
